// File: rtl/activation_unpacker_pkg.sv
// Shared precision definitions for the activation unpacker: precision codes,
// element widths and the unpacker state encoding.
package activation_unpacker_pkg;

  localparam int LOG_ALLOWED_PRECISIONS = 3;

  localparam logic [LOG_ALLOWED_PRECISIONS-1:0] PREC_INT8           = 3'd0;
  localparam logic [LOG_ALLOWED_PRECISIONS-1:0] PREC_INT16          = 3'd1;
  localparam logic [LOG_ALLOWED_PRECISIONS-1:0] PREC_INT32          = 3'd2;
  localparam logic [LOG_ALLOWED_PRECISIONS-1:0] PREC_INT64          = 3'd3;
  localparam logic [LOG_ALLOWED_PRECISIONS-1:0] PREC_NO_COMPUTATION = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_VALID = 2'd2
  } act_state_e;

  // Element width in bits for a precision code; 0 marks a non-computing code.
  function automatic int prec_width(input logic [LOG_ALLOWED_PRECISIONS-1:0] p);
    case (p)
      PREC_INT8:  prec_width = 8;
      PREC_INT16: prec_width = 16;
      PREC_INT32: prec_width = 32;
      PREC_INT64: prec_width = 64;
      default:    prec_width = 0;
    endcase
  endfunction

  function automatic int words_needed(input int columns, input int fifo_w, input int w);
    words_needed = (columns + (fifo_w / w) - 1) / (fifo_w / w);
  endfunction

endpackage

// File: rtl/activation_unpacker_act_lane_slicer.sv
// Combinational lane slicer: maps one packed FIFO word onto lane write enables
// and extended lane values. ACT_UNPACK_SIGNED_EN selects sign extension.
module act_lane_slicer
  import activation_unpacker_pkg::*;
#(
  parameter int COLUMNS = 3,
  parameter int FW      = 64,
  parameter int MW      = 64,
  parameter int CNT_W   = 3
) (
  input  logic [FW-1:0]                     word,
  input  logic [CNT_W-1:0]                  word_idx,
  input  logic [LOG_ALLOWED_PRECISIONS-1:0] precision,
  output logic [COLUMNS-1:0]                lane_we,
  output logic [COLUMNS-1:0][MW-1:0]        lane_val
);

`ifdef ACT_UNPACK_SIGNED_EN
  localparam logic SIGN_EXT = 1'b1;
`else
  localparam logic SIGN_EXT = 1'b0;
`endif

  function automatic logic [MW-1:0] extend(input logic [MW-1:0] raw, input int w, input logic msb);
    logic [MW-1:0] res;
    res = raw;
    for (int b = 0; b < MW; b++) begin
      if ((b >= w) && SIGN_EXT && msb) begin
        res[b] = 1'b1;
      end
    end
    return res;
  endfunction

  for (genvar i = 0; i < COLUMNS; i++) begin : g_lane
    localparam int E8  = FW / 8;
    localparam int E16 = FW / 16;
    localparam int E32 = FW / 32;
    localparam int E64 = FW / 64;
    localparam int I8  = i / E8;
    localparam int I16 = i / E16;
    localparam int I32 = i / E32;
    localparam int I64 = i / E64;
    localparam int P8  = (i % E8) * 8;
    localparam int P16 = (i % E16) * 16;
    localparam int P32 = (i % E32) * 32;
    localparam int P64 = (i % E64) * 64;

    logic          we_s;
    logic          msb_s;
    logic [MW-1:0] raw_s;
    int            w_s;

    // Select this lane's element position and owning word for the precision
    always_comb begin
      we_s  = 1'b0;
      msb_s = 1'b0;
      raw_s = '0;
      w_s   = 0;
      case (precision)
        PREC_INT8: begin
          we_s  = (word_idx == CNT_W'(I8));
          raw_s = MW'(word[P8 +: 8]);
          msb_s = word[P8 + 7];
          w_s   = 8;
        end
        PREC_INT16: begin
          we_s  = (word_idx == CNT_W'(I16));
          raw_s = MW'(word[P16 +: 16]);
          msb_s = word[P16 + 15];
          w_s   = 16;
        end
        PREC_INT32: begin
          we_s  = (word_idx == CNT_W'(I32));
          raw_s = MW'(word[P32 +: 32]);
          msb_s = word[P32 + 31];
          w_s   = 32;
        end
        PREC_INT64: begin
          we_s  = (word_idx == CNT_W'(I64));
          raw_s = MW'(word[P64 +: 64]);
          msb_s = word[P64 + 63];
          w_s   = 64;
        end
        default: begin
          we_s = 1'b0;
        end
      endcase
    end

    assign lane_we[i]  = we_s;
    assign lane_val[i] = extend(raw_s, w_s, msb_s);
  end

endmodule

// File: rtl/activation_unpacker.sv
// Activation unpacker: collects packed FIFO words into one COLUMNS-lane vector
// and hands it to the MXU. ACT_UNPACK_SIGNED_EN (in the slicer) selects sign extension.
module activation_unpacker
  import activation_unpacker_pkg::*;
#(
  parameter int COLUMNS            = 3,
  parameter int DATA_WIDTH_FIFO_IN = 64,
  parameter int DATA_WIDTH_MAC     = 64
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              enable_load_activation_data,
  input  logic [LOG_ALLOWED_PRECISIONS-1:0] data_precision,
  input  logic [DATA_WIDTH_FIFO_IN-1:0]     infifo_data,
  input  logic                              infifo_valid,
  input  logic                              act_ready,
  output logic [COLUMNS*DATA_WIDTH_MAC-1:0] act_out,
  output logic                              act_valid,
  output logic                              busy,
  output logic                              overflow,
  output logic                              bad_precision
);

  localparam int CNT_W = $clog2(COLUMNS) + 1;
  localparam int N8    = words_needed(COLUMNS, DATA_WIDTH_FIFO_IN, prec_width(PREC_INT8));
  localparam int N16   = words_needed(COLUMNS, DATA_WIDTH_FIFO_IN, prec_width(PREC_INT16));
  localparam int N32   = words_needed(COLUMNS, DATA_WIDTH_FIFO_IN, prec_width(PREC_INT32));
  localparam int N64   = words_needed(COLUMNS, DATA_WIDTH_FIFO_IN, prec_width(PREC_INT64));

  act_state_e                               state_q, state_d;
  logic [CNT_W-1:0]                         word_cnt_q, word_cnt_d;
  logic [LOG_ALLOWED_PRECISIONS-1:0]        prec_q, prec_d;
  logic [COLUMNS-1:0][DATA_WIDTH_MAC-1:0]   lanes_q, lanes_d;
  logic                                     act_valid_q, busy_q, overflow_q, bad_precision_q;
  logic                                     overflow_d, bad_precision_d;

  logic [LOG_ALLOWED_PRECISIONS-1:0]        eff_prec_s;
  logic [CNT_W-1:0]                         word_idx_s;
  logic [CNT_W-1:0]                         n_words_s;
  logic                                     take_word_s;
  logic [COLUMNS-1:0]                       lane_we_s;
  logic [COLUMNS-1:0][DATA_WIDTH_MAC-1:0]   lane_val_s;

  // A word arriving with the strobe belongs to the new vector as word 0
  assign eff_prec_s = enable_load_activation_data ? data_precision : prec_q;
  assign word_idx_s = enable_load_activation_data ? '0 : word_cnt_q;

  act_lane_slicer #(
    .COLUMNS (COLUMNS),
    .FW      (DATA_WIDTH_FIFO_IN),
    .MW      (DATA_WIDTH_MAC),
    .CNT_W   (CNT_W)
  ) u_slicer (
    .word      (infifo_data),
    .word_idx  (word_idx_s),
    .precision (eff_prec_s),
    .lane_we   (lane_we_s),
    .lane_val  (lane_val_s)
  );

  // Words required to fill every lane at the effective precision
  always_comb begin
    case (eff_prec_s)
      PREC_INT8:  n_words_s = CNT_W'(N8);
      PREC_INT16: n_words_s = CNT_W'(N16);
      PREC_INT32: n_words_s = CNT_W'(N32);
      PREC_INT64: n_words_s = CNT_W'(N64);
      default:    n_words_s = '0;
    endcase
  end

  // Next-state, counter and lane update
  always_comb begin
    state_d         = state_q;
    word_cnt_d      = word_cnt_q;
    prec_d          = prec_q;
    lanes_d         = lanes_q;
    overflow_d      = 1'b0;
    bad_precision_d = 1'b0;
    take_word_s     = 1'b0;

    if (enable_load_activation_data) begin
      state_d     = ST_FILL;
      word_cnt_d  = '0;
      prec_d      = data_precision;
      lanes_d     = '0;
      take_word_s = infifo_valid;
    end else begin
      case (state_q)
        ST_IDLE: begin
          overflow_d = infifo_valid;
        end
        ST_FILL: begin
          take_word_s = infifo_valid;
        end
        ST_VALID: begin
          overflow_d = infifo_valid;
          if (act_ready) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_VALID;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    if (take_word_s) begin
      if (eff_prec_s <= PREC_INT64) begin
        for (int i = 0; i < COLUMNS; i++) begin
          if (lane_we_s[i]) begin
            lanes_d[i] = lane_val_s[i];
          end else begin
            lanes_d[i] = lanes_d[i];
          end
        end
        word_cnt_d = word_idx_s + CNT_W'(1);
        if ((word_idx_s + CNT_W'(1)) == n_words_s) begin
          state_d = ST_VALID;
        end else begin
          state_d = ST_FILL;
        end
      end else begin
        bad_precision_d = 1'b1;
      end
    end
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= ST_IDLE;
      word_cnt_q      <= '0;
      prec_q          <= PREC_NO_COMPUTATION;
      lanes_q         <= '0;
      act_valid_q     <= 1'b0;
      busy_q          <= 1'b0;
      overflow_q      <= 1'b0;
      bad_precision_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      word_cnt_q      <= word_cnt_d;
      prec_q          <= prec_d;
      lanes_q         <= lanes_d;
      act_valid_q     <= (state_d == ST_VALID);
      busy_q          <= (state_d == ST_FILL);
      overflow_q      <= overflow_d;
      bad_precision_q <= bad_precision_d;
    end
  end

  assign act_out       = lanes_q;
  assign act_valid     = act_valid_q;
  assign busy          = busy_q;
  assign overflow      = overflow_q;
  assign bad_precision = bad_precision_q;

endmodule
